// File: rtl/sram_responder.sv
// sram_responder: SLC-3 SRAM bus target with power-up clear, preload port, pipelined reads and access counters
module sram_responder #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset_ah,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       Data_to_SRAM,
  input  logic              OE,
  input  logic              WE,
  output logic [15:0]       Data_from_SRAM,
  output logic              Ready,
  input  logic              Load_En,
  input  logic [ADDR_W-1:0] Load_Addr,
  input  logic [15:0]       Load_Data,
  output logic [15:0]       RdCount,
  output logic [15:0]       WrCount
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [15:0]        mem [DEPTH];
  logic [15:0]        pipe_d [READ_LAT];
  logic [READ_LAT-1:0] pipe_v;
  logic               run, ld, wr, rd, mem_we;
  logic [ADDR_W-1:0]  a, mem_a;
  logic [15:0]        mem_d;
  logic               unused_addr;
  assign unused_addr = ^ADDR[15:ADDR_W];
  always_comb begin
    a      = ADDR[ADDR_W-1:0];
    run    = state == RUN;
    ld     = run && Load_En;
    wr     = run && !Load_En && !WE;
    rd     = run && !Load_En && WE && !OE;
    mem_we = !run || ld || wr;
    mem_a  = !run ? ptr : ld ? Load_Addr : a;
    mem_d  = !run ? 16'h0000 : ld ? Load_Data : Data_to_SRAM;
  end
  always_ff @(posedge Clk)
    if (mem_we) mem[mem_a] <= mem_d;
  // Data stages need no reset: only the valid bits decide what reaches the output
  always_ff @(posedge Clk) begin
    if (rd) pipe_d[0] <= mem[a];
    for (int i = 1; i < READ_LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end
  always_ff @(posedge Clk or posedge Reset_ah)
    if (Reset_ah) begin
      state          <= CLEAR;
      ptr            <= '0;
      Ready          <= 1'b0;
      RdCount        <= 16'h0000;
      WrCount        <= 16'h0000;
      pipe_v         <= '0;
      Data_from_SRAM <= 16'h0000;
    end else begin
      if (!run) begin
        ptr <= ptr + ADDR_W'(1);
        if (ptr == ADDR_W'(DEPTH-1)) begin
          state <= RUN;
          Ready <= 1'b1;
        end
      end
      if (wr && ~&WrCount) WrCount <= WrCount + 16'd1;
      if (rd && ~&RdCount) RdCount <= RdCount + 16'd1;
      pipe_v[0] <= rd;
      for (int i = 1; i < READ_LAT; i++) pipe_v[i] <= pipe_v[i-1];
      if (pipe_v[READ_LAT-1]) Data_from_SRAM <= pipe_d[READ_LAT-1];
    end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: two responders (read latency 2 and 3) on one shared bus, checked against a word-level model
module tb_sram_responder;
  logic        Clk = 0, Reset_ah = 1;
  logic [15:0] ADDR = 0, Data_to_SRAM = 0, Load_Data = 0;
  logic        OE = 1, WE = 1, Load_En = 0;
  logic [3:0]  Load_Addr = 0;
  logic [15:0] dout2, dout3, rdc2, rdc3, wrc2, wrc3;
  logic        rdy2, rdy3;
  int n_cmp = 0, n_bad = 0;

  sram_responder #(.ADDR_W(4), .READ_LAT(2)) u2 (
    .Clk(Clk), .Reset_ah(Reset_ah), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .OE(OE), .WE(WE),
    .Data_from_SRAM(dout2), .Ready(rdy2), .Load_En(Load_En), .Load_Addr(Load_Addr),
    .Load_Data(Load_Data), .RdCount(rdc2), .WrCount(wrc2));
  sram_responder #(.ADDR_W(4), .READ_LAT(3)) u3 (
    .Clk(Clk), .Reset_ah(Reset_ah), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .OE(OE), .WE(WE),
    .Data_from_SRAM(dout3), .Ready(rdy3), .Load_En(Load_En), .Load_Addr(Load_Addr),
    .Load_Data(Load_Data), .RdCount(rdc3), .WrCount(wrc3));

  always #5 Clk = ~Clk;

  // Model: memory image, clear-cycle count, counters, and one delay line per latency
  logic [15:0] mem_m [16];
  int          m_cnt;
  logic [15:0] m_rd, m_wr, m_out2, m_out3;
  logic [16:0] q2 [$], q3 [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = 16'h0000;
    m_cnt = 0; m_rd = 0; m_wr = 0; m_out2 = 0; m_out3 = 0;
    q2 = {17'h0, 17'h0};
    q3 = {17'h0, 17'h0, 17'h0};
  endtask

  task automatic model_edge();
    logic [16:0] e, p;
    e = 17'h0;
    if (m_cnt < 16) m_cnt++;
    else if (Load_En) mem_m[Load_Addr] = Load_Data;
    else if (!WE) begin
      mem_m[ADDR[3:0]] = Data_to_SRAM;
      if (m_wr != 16'hFFFF) m_wr++;
    end else if (!OE) begin
      e = {1'b1, mem_m[ADDR[3:0]]};
      if (m_rd != 16'hFFFF) m_rd++;
    end
    q2.push_back(e); p = q2.pop_front(); if (p[16]) m_out2 = p[15:0];
    q3.push_back(e); p = q3.pop_front(); if (p[16]) m_out3 = p[15:0];
  endtask

  task automatic check_all();
    chk("dout_lat2", dout2, m_out2);
    chk("dout_lat3", dout3, m_out3);
    chk("ready_lat2", 16'(rdy2), 16'(m_cnt == 16));
    chk("ready_lat3", 16'(rdy3), 16'(m_cnt == 16));
    chk("rdcount", rdc2, m_rd);
    chk("wrcount", wrc2, m_wr);
    chk("rdcount_lat3", rdc3, m_rd);
    chk("wrcount_lat3", wrc3, m_wr);
  endtask

  task automatic tick();
    @(posedge Clk);
    if (!Reset_ah) model_edge();
    @(negedge Clk);
    check_all();
  endtask

  task automatic do_reset();
    Reset_ah = 1;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
    Reset_ah = 0;
  endtask

  task automatic drive(input logic le, input logic [3:0] la, input logic [15:0] ld,
                       input logic we, input logic oe, input logic [15:0] a, input logic [15:0] d);
    Load_En = le; Load_Addr = la; Load_Data = ld; WE = we; OE = oe; ADDR = a; Data_to_SRAM = d;
  endtask

  task automatic idle();
    drive(0, 0, 0, 1, 1, 0, 0);
  endtask

  task automatic run_clear();
    idle();
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("ready_during_clear", 16'(rdy2), 16'(k >= 16));
    end
  endtask

  typedef struct {
    logic le; logic [3:0] la; logic [15:0] ld;
    logic we, oe; logic [15:0] a, d;
    logic [15:0] e_out, e_rd, e_wr;
  } vec_t;
  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1, 3, 16'h1234, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0};
    tbl[1]  = '{0, 0, 16'h0000, 1, 0, 16'h0003, 16'h0000, 16'h0000, 1, 0};
    tbl[2]  = '{0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0};
    tbl[3]  = '{0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h1234, 1, 0};
    tbl[4]  = '{0, 0, 16'h0000, 0, 0, 16'h0005, 16'hBEEF, 16'h1234, 1, 1};
    tbl[5]  = '{0, 0, 16'h0000, 1, 0, 16'h0005, 16'h0000, 16'h1234, 2, 1};
    tbl[6]  = '{0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h1234, 2, 1};
    tbl[7]  = '{0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'hBEEF, 2, 1};
    tbl[8]  = '{1, 7, 16'h7777, 0, 1, 16'h0007, 16'hDEAD, 16'hBEEF, 2, 1};
    tbl[9]  = '{0, 0, 16'h0000, 1, 0, 16'h0017, 16'h0000, 16'hBEEF, 3, 1};
    tbl[10] = '{0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'hBEEF, 3, 1};
    tbl[11] = '{0, 0, 16'h0000, 0, 1, 16'h0010, 16'h5A5A, 16'h7777, 3, 2};
    tbl[12] = '{0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h7777, 4, 2};
    tbl[13] = '{0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h7777, 4, 2};
    tbl[14] = '{0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h5A5A, 4, 2};

    @(negedge Clk);
    do_reset();
    // Bus and preload activity during clear must be ignored
    for (int k = 1; k <= 16; k++) begin
      drive(k == 9, 4'(k), 16'hFFFF, !(k == 5 || k == 12), k[0], 16'(k), 16'hABCD);
      tick();
      chk("ready_during_clear", 16'(rdy2), 16'(k >= 16));
    end
    chk("wrcount_after_clear", wrc2, 16'h0000);
    for (int k = 0; k < 19; k++) begin
      if (k < 16) drive(0, 0, 0, 1, 0, 16'(k), 0); else idle();
      tick();
      chk("read_cleared", dout2, 16'h0000);
    end

    do_reset();
    run_clear();
    foreach (tbl[i]) begin
      drive(tbl[i].le, tbl[i].la, tbl[i].ld, tbl[i].we, tbl[i].oe, tbl[i].a, tbl[i].d);
      tick();
      chk($sformatf("tbl%0d_dout", i), dout2, tbl[i].e_out);
      chk($sformatf("tbl%0d_rdcount", i), rdc2, tbl[i].e_rd);
      chk($sformatf("tbl%0d_wrcount", i), wrc2, tbl[i].e_wr);
    end

    // Back-to-back reads at latency 3
    for (int k = 0; k < 4; k++) begin
      drive(1, 4'(k), 16'hA000 + 16'(k), 1, 1, 0, 0);
      tick();
    end
    for (int k = 0; k < 9; k++) begin
      if (k < 4) drive(0, 0, 0, 1, 0, 16'(k), 0); else idle();
      tick();
      if (k >= 3) chk("b2b_lat3", dout3, 16'hA000 + 16'(k >= 6 ? 3 : k - 3));
    end

    // Reset mid-clear restarts the full clear
    do_reset();
    for (int k = 0; k < 7; k++) tick();
    do_reset();
    chk("ready_reset_midclear", 16'(rdy2), 16'h0000);
    run_clear();

    // Reset with reads in flight: outputs drop at once, the pending word never appears
    drive(1, 2, 16'hC0DE, 1, 1, 0, 0); tick();
    drive(1, 9, 16'h9999, 1, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 16'h0002, 0); tick();
    idle(); tick(); tick(); tick();
    chk("pre_reset_dout3", dout3, 16'hC0DE);
    drive(0, 0, 0, 1, 0, 16'h0009, 0); tick();
    idle();
    Reset_ah = 1;
    #1;
    chk("reset_inflight_dout2", dout2, 16'h0000);
    chk("reset_inflight_dout3", dout3, 16'h0000);
    chk("reset_inflight_ready", 16'(rdy3), 16'h0000);
    model_reset();
    @(negedge Clk);
    Reset_ah = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("no_ghost_read", dout3, 16'h0000);
      chk("ready_after_reset", 16'(rdy3), 16'(k >= 16));
    end

    // Random traffic against the model, with occasional resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      drive($urandom_range(0, 7) == 0, 4'($urandom), 16'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom), 16'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
